des_nic_engine_sequencer: RTL and testbench

Round sequencer for the DES processing element of a NoC node. It receives the packet-complete strobe from the NiC input control logic, then drives the engine's load, round and key-schedule controls for a fixed number of rounds. It holds the result for the NiC output block until that block acknowledges it. It drives the `busy_engine` flag back to the NiC input control logic, so the input block can only hand over a new packet when the engine is free.

---
 rtl/des_nic_engine_sequencer.sv | 110 +++++++++++
 tb/tb_des_nic_engine_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_nic_engine_sequencer.sv
// Round sequencer for the NoC DES processing element: load, N rounds, then hold result until ack.
// Define DES_SEQ_DECRYPT_EN to build the decrypt mode register and decrypt key schedule.
module des_nic_engine_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_strobe_din,
  input  logic       decrypt_din,
  input  logic       result_ack_din,
  output logic       busy_engine_dout,
  output logic       load_dout,
  output logic       round_enable_dout,
  output logic [3:0] round_count_dout,
  output logic [1:0] key_shift_dout,
  output logic       key_shift_right_dout,
  output logic       last_round_dout,
  output logic       mode_dout,
  output logic       result_valid_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       is_last;
  logic       is_decrypt;

  assign is_last = (count_q == LAST_ROUND);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:  if (start_strobe_din) state_d = S_LOAD;
      S_LOAD: begin
        count_d = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // Counter holds at the last index instead of wrapping.
        if (is_last) state_d = S_DONE;
        else         count_d = count_q + 4'd1;
      end
      S_DONE:  if (result_ack_din) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DES_SEQ_DECRYPT_EN
  logic mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (state_q == S_IDLE && start_strobe_din) mode_d = decrypt_din;
  end

  assign is_decrypt = mode_q;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt_din;
  assign is_decrypt     = 1'b0;
`endif

  // All outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    busy_engine_dout     = (state_q != S_IDLE);
    load_dout            = (state_q == S_LOAD);
    round_enable_dout    = (state_q == S_ROUND);
    round_count_dout     = count_q;
    last_round_dout      = (state_q == S_ROUND) && is_last;
    result_valid_dout    = (state_q == S_DONE);
    mode_dout            = is_decrypt;
    key_shift_dout       = 2'd0;
    key_shift_right_dout = 1'b0;
    if (state_q == S_ROUND) begin
      key_shift_right_dout = is_decrypt;
      case (count_q)
        4'd0:               key_shift_dout = is_decrypt ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:  key_shift_dout = 2'd1;
        default:            key_shift_dout = 2'd2;
      endcase
    end
  end

endmodule

// File: tb/tb_des_nic_engine_sequencer.sv
// Self-checking bench for des_nic_engine_sequencer: phase-based reference model plus directed literal checks.
module tb_des_nic_engine_sequencer;

  localparam int R = 16;
`ifdef DES_SEQ_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic       ack = 1'b0;
  logic       busy, load, round_en, key_right, last, mode, valid;
  logic [3:0] count;
  logic [1:0] shift;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int enc_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_nic_engine_sequencer #(.ROUNDS(R)) dut (
    .clk                  (clk),
    .reset                (rst),
    .start_strobe_din     (start),
    .decrypt_din          (decrypt),
    .result_ack_din       (ack),
    .busy_engine_dout     (busy),
    .load_dout            (load),
    .round_enable_dout    (round_en),
    .round_count_dout     (count),
    .key_shift_dout       (shift),
    .key_shift_right_dout (key_right),
    .last_round_dout      (last),
    .mode_dout            (mode),
    .result_valid_dout    (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: m_t is the phase since an accepted start
  // (-1 idle, 0 load, 1..R round m_t-1, R+1 waiting for ack).
  int         m_t    = -1;
  logic [3:0] m_cnt  = '0;
  logic       m_mode = 1'b0;
  logic       m_on   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t    <= -1;
      m_cnt  <= '0;
      m_mode <= 1'b0;
      m_on   <= 1'b1;
    end else if (m_t < 0) begin
      if (start) begin
        m_t    <= 0;
        m_mode <= DEC_EN ? decrypt : 1'b0;
      end
    end else if (m_t == 0) begin
      m_t   <= 1;
      m_cnt <= '0;
    end else if (m_t <= R) begin
      m_t <= m_t + 1;
      if (int'(m_cnt) < R - 1) m_cnt <= m_cnt + 4'd1;
    end else if (ack) begin
      m_t <= -1;
    end
  end

  // Single compare process: every output against the model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (m_on) begin
      logic in_round;
      int   exp_shift;
      in_round  = (m_t >= 1) && (m_t <= R);
      exp_shift = 0;
      if (in_round) exp_shift = m_mode ? dec_tab[m_t - 1] : enc_tab[m_t - 1];
      check("busy",      32'(busy),      32'(m_t >= 0));
      check("load",      32'(load),      32'(m_t == 0));
      check("round_en",  32'(round_en),  32'(in_round));
      check("count",     32'(count),     32'(m_cnt));
      check("shift",     32'(shift),     32'(exp_shift));
      check("shift_dir", 32'(key_right), 32'(in_round && m_mode));
      check("last",      32'(last),      32'(m_t == R));
      check("mode",      32'(mode),      32'(m_mode));
      check("valid",     32'(valid),     32'(m_t > R));
    end
  end

  task automatic step(input logic r, input logic st, input logic dec, input logic a);
    @(negedge clk);
    rst     = r;
    start   = st;
    decrypt = dec;
    ack     = a;
  endtask

  // One full packet with literal timing and key-shift expectations; ack given on the first valid cycle.
  task automatic run_one(input string tag, input logic dec, input int tab[16]);
    step(1'b0, 1'b1, dec, 1'b0);
    for (int k = 1; k <= R + 2; k++) begin
      step(1'b0, 1'b0, 1'b0, k == R + 2);
      check({tag, "_load"}, 32'(load), 32'(k == 1));
      check({tag, "_last"}, 32'(last), 32'(k == R + 1));
      check({tag, "_valid"}, 32'(valid), 32'(k == R + 2));
      if (k >= 2 && k <= R + 1) begin
        check({tag, "_cnt"}, 32'(count), 32'(k - 2));
        check({tag, "_seq"}, 32'(shift), 32'(tab[k - 2]));
        check({tag, "_dir"}, 32'(key_right), 32'(DEC_EN && dec));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_mode_hold"}, 32'(mode), 32'(DEC_EN && dec));
  endtask

  initial begin
    int  v1;
    int  rounds;
    bit  found;

    // Reset with a start pulse inside it, then idle.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("idle_outs", {busy, load, round_en, count, shift, key_right, last, mode, valid}, 32'd0);
    end

    run_one("enc", 1'b0, enc_tab);
`ifdef DES_SEQ_DECRYPT_EN
    run_one("dec", 1'b1, dec_tab);
`else
    run_one("dec", 1'b1, enc_tab);
`endif

    // Stalled ack with ignored starts during the run and the stall.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= R + 1; k++) step(1'b0, (k == 5) || (k == 10), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_valid_rise", 32'(valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 4) == 0, 1'b1, 1'b0);
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("stall_valid_at_ack", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_valid_off", 32'(valid), 32'd0);
    check("stall_busy_off", 32'(busy), 32'd0);
    check("stall_mode", 32'(mode), 32'd0);

    // Back-to-back with ack tied high.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= R + 2; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_first_valid", 32'(valid), 32'd1);
    v1 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("b2b_idle_gap", 32'(busy), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid) begin
        found = 1'b1;
        check("b2b_period", 32'(cyc - v1), 32'(R + 3));
        break;
      end
    end
    if (!found) check("b2b_timeout", 32'd0, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at round index 7, then a fresh full run.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) step(k == 9, 1'b0, 1'b0, 1'b0);
    check("mid_reset_idx", 32'(count), 32'd7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_reset_outs", {busy, load, round_en, count, shift, key_right, last, mode, valid}, 32'd0);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("mid_reset_no_valid", 32'(valid), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rounds = 0;
    found  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (round_en) rounds++;
      if (valid) begin
        found = 1'b1;
        check("fresh_latency", 32'(i), 32'(R + 2));
        break;
      end
    end
    if (!found) check("fresh_timeout", 32'd0, 32'd1);
    check("fresh_rounds", 32'(rounds), 32'(R));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
